// File: rtl/interrupt_request_priority_resolver.sv
// IRR / ISR / priority resolver front end for an 8259A-style controller.
// Optional macro IRQ_SYNC_EN: when defined, the IR pins pass through
// SYNC_STAGES synchronizer flops before the edge/level detection.
module interrupt_request_priority_resolver #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic [7:0] interrupt_request_pin,
  input  logic       write_initial_command_word_1,
  input  logic       level_or_edge_toriggered_config,
  input  logic       special_fully_nest_config,
  input  logic [7:0] interrupt_mask,
  input  logic [7:0] interrupt_special_mask,
  input  logic [7:0] end_of_interrupt,
  input  logic [2:0] priority_rotate,
  input  logic       freeze,
  input  logic       latch_in_service,
  input  logic [7:0] clear_interrupt_request,
  output logic [7:0] interrupt,
  output logic [7:0] highest_level_in_service,
  output logic [7:0] interrupt_request_register,
  output logic [7:0] in_service_register
);

  if (SYNC_STAGES != 2 && SYNC_STAGES != 3) begin : g_bad_sync_stages
    $error("SYNC_STAGES must be 2 or 3");
  end

  logic [7:0] irq_s;
  logic [7:0] prev_q;
  logic [7:0] irr_q;
  logic [7:0] irr_d;
  logic [7:0] isr_q;
  logic [7:0] isr_d;
  logic [7:0] interrupt_q;
  logic [7:0] interrupt_d;

`ifdef IRQ_SYNC_EN
  logic [7:0] sync_q [SYNC_STAGES];

  // Shift the raw pins through the synchronizer chain.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      for (int k = 0; k < SYNC_STAGES; k++) sync_q[k] <= 8'h00;
    end else begin
      sync_q[0] <= interrupt_request_pin;
      for (int k = 1; k < SYNC_STAGES; k++) sync_q[k] <= sync_q[k-1];
    end
  end

  assign irq_s = sync_q[SYNC_STAGES-1];
`else
  assign irq_s = interrupt_request_pin;
`endif

  // Rotate so that the highest-priority level lands on bit 0.
  function automatic logic [7:0] rot_r(input logic [7:0] v, input logic [2:0] s);
    logic [15:0] d;
    d = {v, v} >> s;
    return d[7:0];
  endfunction

  // Inverse rotation back to physical IR numbering.
  function automatic logic [7:0] rot_l(input logic [7:0] v, input logic [2:0] s);
    logic [15:0] d;
    d = {v, v} << s;
    return d[15:8];
  endfunction

  // Isolate the lowest set bit (highest priority in rotated space).
  function automatic logic [7:0] lowest_bit(input logic [7:0] v);
    return v & (~v + 8'd1);
  endfunction

  logic [2:0] shift;
  logic [7:0] req_rot;
  logic [7:0] isr_rot;
  logic [7:0] req;

  assign shift   = priority_rotate + 3'd1;
  assign req_rot = lowest_bit(rot_r(irr_q & ~interrupt_mask, shift));
  assign isr_rot = lowest_bit(rot_r(isr_q & ~interrupt_special_mask, shift));
  assign req     = rot_l(req_rot, shift);

  assign highest_level_in_service = rot_l(isr_rot, shift);

  // Per-bit IRR next state: clear, then freeze, then edge/level capture.
  for (genvar gi = 0; gi < 8; gi++) begin : g_irr
    always_comb begin
      irr_d[gi] = irr_q[gi];
      if (clear_interrupt_request[gi]) begin
        irr_d[gi] = 1'b0;
      end else if (freeze) begin
        irr_d[gi] = irr_q[gi];
      end else if (level_or_edge_toriggered_config) begin
        irr_d[gi] = irq_s[gi];
      end else if (irq_s[gi] && !prev_q[gi]) begin
        irr_d[gi] = 1'b1;
      end else if (!irq_s[gi]) begin
        irr_d[gi] = 1'b0;
      end
    end
  end

  // Nesting decision: one-hot rotated vectors compare directly as
  // numbers, smaller value means higher priority.
  always_comb begin
    interrupt_d = 8'h00;
    if (req_rot != 8'h00) begin
      if (isr_rot == 8'h00 || req_rot < isr_rot ||
          (special_fully_nest_config && req_rot == isr_rot)) begin
        interrupt_d = req;
      end
    end
  end

  // ISR next state: latching the winner beats a simultaneous EOI.
  always_comb begin
    isr_d = isr_q;
    if (latch_in_service) isr_d = isr_q | interrupt_q;
    isr_d = isr_d & ~(end_of_interrupt & ~(latch_in_service ? interrupt_q : 8'h00));
  end

  // State registers; ICW1 preloads edge history so only a fresh edge requests.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      prev_q      <= 8'h00;
      irr_q       <= 8'h00;
      isr_q       <= 8'h00;
      interrupt_q <= 8'h00;
    end else if (write_initial_command_word_1) begin
      prev_q      <= 8'hFF;
      irr_q       <= 8'h00;
      isr_q       <= 8'h00;
      interrupt_q <= 8'h00;
    end else begin
      prev_q      <= irq_s;
      irr_q       <= irr_d;
      isr_q       <= isr_d;
      interrupt_q <= interrupt_d;
    end
  end

  assign interrupt                  = interrupt_q;
  assign interrupt_request_register = irr_q;
  assign in_service_register        = isr_q;

endmodule

// File: tb/tb_interrupt_request_priority_resolver.sv
// Directed bench for the IRR/ISR priority resolver (default build).
module tb_interrupt_request_priority_resolver;

  logic       clock = 1'b0;
  logic       reset_n;
  logic [7:0] interrupt_request_pin;
  logic       write_initial_command_word_1;
  logic       level_or_edge_toriggered_config;
  logic       special_fully_nest_config;
  logic [7:0] interrupt_mask;
  logic [7:0] interrupt_special_mask;
  logic [7:0] end_of_interrupt;
  logic [2:0] priority_rotate;
  logic       freeze;
  logic       latch_in_service;
  logic [7:0] clear_interrupt_request;
  logic [7:0] interrupt;
  logic [7:0] highest_level_in_service;
  logic [7:0] interrupt_request_register;
  logic [7:0] in_service_register;

  int checks = 0;
  int fails  = 0;

  always #5 clock = ~clock;

  interrupt_request_priority_resolver dut (
    .clock                           (clock),
    .reset_n                         (reset_n),
    .interrupt_request_pin           (interrupt_request_pin),
    .write_initial_command_word_1    (write_initial_command_word_1),
    .level_or_edge_toriggered_config (level_or_edge_toriggered_config),
    .special_fully_nest_config       (special_fully_nest_config),
    .interrupt_mask                  (interrupt_mask),
    .interrupt_special_mask          (interrupt_special_mask),
    .end_of_interrupt                (end_of_interrupt),
    .priority_rotate                 (priority_rotate),
    .freeze                          (freeze),
    .latch_in_service                (latch_in_service),
    .clear_interrupt_request         (clear_interrupt_request),
    .interrupt                       (interrupt),
    .highest_level_in_service        (highest_level_in_service),
    .interrupt_request_register      (interrupt_request_register),
    .in_service_register             (in_service_register)
  );

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%02h expected 0x%02h", tag, obs, exp);
    end
    $display("check %-16s observed 0x%02h expected 0x%02h", tag, obs, exp);
  endtask

  initial begin
    reset_n = 1'b0;
    interrupt_request_pin = 8'h00;
    write_initial_command_word_1 = 1'b0;
    level_or_edge_toriggered_config = 1'b0;
    special_fully_nest_config = 1'b0;
    interrupt_mask = 8'h00;
    interrupt_special_mask = 8'h00;
    end_of_interrupt = 8'h00;
    priority_rotate = 3'd7;
    freeze = 1'b0;
    latch_in_service = 1'b0;
    clear_interrupt_request = 8'h00;

    // Reset state
    step();
    check("rst_irr", interrupt_request_register, 8'h00);
    check("rst_isr", in_service_register, 8'h00);
    check("rst_int", interrupt, 8'h00);
    check("rst_hlis", highest_level_in_service, 8'h00);
    reset_n = 1'b1;

    // Edge mode, IR3
    interrupt_request_pin = 8'h08; step();
    check("edge_irr", interrupt_request_register, 8'h08);
    check("edge_int_lat0", interrupt, 8'h00);
    step();
    check("edge_int", interrupt, 8'h08);
    clear_interrupt_request = 8'h08; step();
    check("edge_clr_irr", interrupt_request_register, 8'h00);
    clear_interrupt_request = 8'h00; step();
    check("edge_noretrig", interrupt_request_register, 8'h00);
    check("edge_int_idle", interrupt, 8'h00);
    interrupt_request_pin = 8'h00; step();

    // Mask and rotation
    interrupt_request_pin = 8'h24; step();
    check("irr_24", interrupt_request_register, 8'h24);
    interrupt_mask = 8'h04; step();
    check("mask_int", interrupt, 8'h20);
    interrupt_mask = 8'h00; priority_rotate = 3'd2; step();
    check("rot2_int", interrupt, 8'h20);
    priority_rotate = 3'd5; step();
    check("rot5_wrap", interrupt, 8'h04);
    interrupt_mask = 8'hFF; step();
    check("all_masked", interrupt, 8'h00);
    interrupt_mask = 8'h00; priority_rotate = 3'd7; interrupt_request_pin = 8'h00; step();
    step();

    // Nesting and SFNM
    interrupt_request_pin = 8'h02; step(); step();
    check("ir1_int", interrupt, 8'h02);
    latch_in_service = 1'b1; clear_interrupt_request = 8'h02; step();
    check("isr_02", in_service_register, 8'h02);
    check("hlis_02", highest_level_in_service, 8'h02);
    latch_in_service = 1'b0; clear_interrupt_request = 8'h00; step();
    interrupt_request_pin = 8'h00; step();
    interrupt_request_pin = 8'h02; step(); step();
    check("eq_nosfnm", interrupt, 8'h00);
    special_fully_nest_config = 1'b1; step();
    check("eq_sfnm", interrupt, 8'h02);
    special_fully_nest_config = 1'b0; interrupt_request_pin = 8'h03; step(); step();
    check("ir0_preempt", interrupt, 8'h01);
    interrupt_mask = 8'h01; interrupt_special_mask = 8'h02; step();
    check("smask_int", interrupt, 8'h02);
    check("smask_hlis", highest_level_in_service, 8'h00);
    interrupt_mask = 8'h00; interrupt_special_mask = 8'h00;
    end_of_interrupt = 8'h02; interrupt_request_pin = 8'h00; step();
    check("eoi_isr0", in_service_register, 8'h00);
    end_of_interrupt = 8'h00; step();

    // Latch vs EOI, multi-bit EOI
    interrupt_request_pin = 8'h10; step(); step();
    check("ir4_int", interrupt, 8'h10);
    latch_in_service = 1'b1; end_of_interrupt = 8'h10; clear_interrupt_request = 8'h10; step();
    check("set_wins", in_service_register, 8'h10);
    latch_in_service = 1'b0; end_of_interrupt = 8'h00; clear_interrupt_request = 8'h00;
    interrupt_request_pin = 8'h01; step(); step();
    check("ir0_over_ir4", interrupt, 8'h01);
    latch_in_service = 1'b1; clear_interrupt_request = 8'h01; step();
    check("isr_11", in_service_register, 8'h11);
    check("hlis_01", highest_level_in_service, 8'h01);
    latch_in_service = 1'b0; clear_interrupt_request = 8'h00; interrupt_request_pin = 8'h00; step();
    latch_in_service = 1'b1; step();
    check("latch_noint", in_service_register, 8'h11);
    latch_in_service = 1'b0; end_of_interrupt = 8'h11; step();
    check("multi_eoi", in_service_register, 8'h00);
    check("multi_eoi_hlis", highest_level_in_service, 8'h00);
    end_of_interrupt = 8'h00;

    // Level mode with freeze
    level_or_edge_toriggered_config = 1'b1; freeze = 1'b1; interrupt_request_pin = 8'h40; step();
    check("freeze_hold", interrupt_request_register, 8'h00);
    freeze = 1'b0; step();
    check("level_irr", interrupt_request_register, 8'h40);
    step();
    check("level_int", interrupt, 8'h40);
    interrupt_request_pin = 8'h00; step();
    check("level_drop", interrupt_request_register, 8'h00);

    // Build IRR=FF / ISR=81, then reset
    interrupt_request_pin = 8'hFF; step(); step();
    latch_in_service = 1'b1; step();
    latch_in_service = 1'b0; interrupt_mask = 8'h7F; interrupt_special_mask = 8'h01; step();
    check("int_80", interrupt, 8'h80);
    latch_in_service = 1'b1; step();
    latch_in_service = 1'b0;
    check("pre_irr", interrupt_request_register, 8'hFF);
    check("pre_isr", in_service_register, 8'h81);
    reset_n = 1'b0; step();
    check("rst2_irr", interrupt_request_register, 8'h00);
    check("rst2_isr", in_service_register, 8'h00);
    check("rst2_int", interrupt, 8'h00);
    check("rst2_hlis", highest_level_in_service, 8'h00);
    reset_n = 1'b1; interrupt_mask = 8'h00; interrupt_special_mask = 8'h00;
    level_or_edge_toriggered_config = 1'b0; interrupt_request_pin = 8'h00; step();

    // ICW1 with IR4 held high
    interrupt_request_pin = 8'h10; write_initial_command_word_1 = 1'b1; step();
    write_initial_command_word_1 = 1'b0; step();
    check("icw1_block", interrupt_request_register, 8'h00);
    step();
    check("icw1_block2", interrupt_request_register, 8'h00);
    interrupt_request_pin = 8'h00; step();
    interrupt_request_pin = 8'h10; step();
    check("icw1_newedge", interrupt_request_register, 8'h10);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
